// File: rtl/gpsreceiver2_rxcap_if.sv
// Purpose: bundles the front-end pins, capture control, status and sample-RAM
//          write bus of the GPS capture stage.
// Signals:
//   gps_clk_in/gps_sign/gps_mag  front-end sample clock and {sign,mag} data
//   start/abort                  1-cycle control pulses
//   busy/done                    capture status
//   mem_we/mem_a/mem_d           sample RAM write port
//   rx_count_0                   words written since last start
// Modports: master = capture stage, slave = front-end/CSR/RAM side.
interface gpsreceiver2_rxcap_if #(
  parameter int unsigned depth_log2 = 10
);
  logic                  gps_clk_in;
  logic                  gps_sign;
  logic                  gps_mag;
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  mem_we;
  logic [depth_log2-1:0] mem_a;
  logic [31:0]           mem_d;
  logic [depth_log2:0]   rx_count_0;

  modport master (
    input  gps_clk_in, gps_sign, gps_mag, start, abort,
    output busy, done, mem_we, mem_a, mem_d, rx_count_0
  );

  modport slave (
    output gps_clk_in, gps_sign, gps_mag, start, abort,
    input  busy, done, mem_we, mem_a, mem_d, rx_count_0
  );
endinterface

// File: rtl/gpsreceiver2_rxcap.sv
// Purpose: GPS front-end capture. Synchronises the front-end clock/data into
//          sys_clk, packs 16 {sign,mag} samples per 32-bit word (sample 0 in
//          bits [1:0]) and writes the words into the sample RAM until the
//          2^depth_log2-word buffer is full.
// Ports:
//   sys_clk  system clock (also oversamples the front-end clock)
//   sys_rst  asynchronous active-high reset
//   bus      master side of gpsreceiver2_rxcap_if (pins, control, status, RAM)
module gpsreceiver2_rxcap #(
  parameter int unsigned depth_log2 = 10
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  gpsreceiver2_rxcap_if.master bus
);

  localparam int unsigned AW = depth_log2;
  localparam int unsigned CW = depth_log2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((32'd1 << depth_log2) - 32'd1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic sign_s1_q, sign_s2_q;
  logic mag_s1_q, mag_s2_q;
  logic rise_c;

  logic [1:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [31:0]   pack_q, pack_d;
  logic [31:0]   word_c;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [31:0]   mem_d_q, mem_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Two-flop synchronisers; third clock flop for rising-edge detect
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      clk_s3_q  <= 1'b0;
      sign_s1_q <= 1'b0;
      sign_s2_q <= 1'b0;
      mag_s1_q  <= 1'b0;
      mag_s2_q  <= 1'b0;
    end else begin
      clk_s1_q  <= bus.gps_clk_in;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      sign_s1_q <= bus.gps_sign;
      sign_s2_q <= sign_s1_q;
      mag_s1_q  <= bus.gps_mag;
      mag_s2_q  <= mag_s1_q;
    end
  end

  assign rise_c = clk_s2_q & ~clk_s3_q;

  // New sample shifts in at the top so sample 0 lands in [1:0] after 16 shifts
  assign word_c = {sign_s2_q, mag_s2_q, pack_q[31:2]};

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pack_d   = pack_q;
    mem_we_d = 1'b0;
    mem_a_d  = mem_a_q;
    mem_d_d  = mem_d_q;
    cnt_d    = cnt_q;

    if (bus.abort) begin
      // Partial word and any not-yet-issued write are dropped; counters kept
      // for readback unless start arrives together with abort.
      state_d = S_IDLE;
      idx_d   = 4'd0;
      pack_d  = '0;
      if (bus.start) begin
        mem_a_d = '0;
        cnt_d   = '0;
      end
    end else if (bus.start) begin
      state_d = S_CAPTURE;
      idx_d   = 4'd0;
      pack_d  = '0;
      mem_a_d = '0;
      cnt_d   = '0;
    end else if (state_q == S_CAPTURE) begin
      // Account for the write currently on the RAM port
      if (mem_we_q) begin
        cnt_d   = cnt_q + CW'(1);
        mem_a_d = mem_a_q + AW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      if (rise_c) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          mem_we_d = 1'b1;
          mem_d_d  = word_c;
          pack_d   = '0;
        end else begin
          pack_d = word_c;
        end
      end
    end

    busy_d = (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      pack_q   <= '0;
      mem_we_q <= 1'b0;
      mem_a_q  <= '0;
      mem_d_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pack_q   <= pack_d;
      mem_we_q <= mem_we_d;
      mem_a_q  <= mem_a_d;
      mem_d_q  <= mem_d_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_d      = mem_d_q;
  assign bus.rx_count_0 = cnt_q;

endmodule

// File: tb/tb_gpsreceiver2_rxcap.sv
// Purpose: scoreboard bench for gpsreceiver2_rxcap. Two instances (depth 10 and
//          depth 4) share one stimulus stream; expected RAM writes are queued
//          per instance and popped by a monitor on every mem_we.
module tb_gpsreceiver2_rxcap;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst;
  logic gclk, gsign, gmag, start, abort;

  int total;
  int bad;

  wr_t q10[$];
  wr_t q4[$];

  gpsreceiver2_rxcap_if #(.depth_log2(10)) if10 ();
  gpsreceiver2_rxcap_if #(.depth_log2(4))  if4  ();

  assign if10.gps_clk_in = gclk;
  assign if10.gps_sign   = gsign;
  assign if10.gps_mag    = gmag;
  assign if10.start      = start;
  assign if10.abort      = abort;
  assign if4.gps_clk_in  = gclk;
  assign if4.gps_sign    = gsign;
  assign if4.gps_mag     = gmag;
  assign if4.start       = start;
  assign if4.abort       = abort;

  gpsreceiver2_rxcap #(.depth_log2(10)) u_d10 (.sys_clk(clk), .sys_rst(rst), .bus(if10));
  gpsreceiver2_rxcap #(.depth_log2(4))  u_d4  (.sys_clk(clk), .sys_rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we must match the head of its instance's queue
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (if10.mem_we) begin
        if (q10.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr10_unexpected: got write a=%0h d=%h, expected none", if10.mem_a, if10.mem_d);
        end else begin
          e = q10.pop_front();
          chk("wr10_addr", 64'(if10.mem_a), 64'(e.a));
          chk("wr10_data", 64'(if10.mem_d), 64'(e.d));
        end
      end
      if (if4.mem_we) begin
        if (q4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr4_unexpected: got write a=%0h d=%h, expected none", if4.mem_a, if4.mem_d);
        end else begin
          e = q4.pop_front();
          chk("wr4_addr", 64'(if4.mem_a), 64'(e.a));
          chk("wr4_data", 64'(if4.mem_d), 64'(e.d));
        end
      end
    end
  end

  task automatic exp_wr(input bit to10, input bit to4, input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    if (to10) q10.push_back(e);
    if (to4)  q4.push_back(e);
  endtask

  // One front-end sample: clock high 2 cycles, low 2 cycles
  task automatic send(input logic [1:0] sm);
    @(negedge clk);
    gclk  = 1'b1;
    gsign = sm[1];
    gmag  = sm[0];
    @(negedge clk);
    @(negedge clk);
    gclk = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_n(input int n, input logic [1:0] sm);
    for (int i = 0; i < n; i++) send(sm);
  endtask

  task automatic pulse(input logic s, input logic a);
    @(negedge clk);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    gclk  = 1'b0;
    gsign = 1'b0;
    gmag  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Reset values
    chk("rst_busy",  64'(if10.busy),       64'd0);
    chk("rst_done",  64'(if10.done),       64'd0);
    chk("rst_we",    64'(if10.mem_we),     64'd0);
    chk("rst_addr",  64'(if10.mem_a),      64'd0);
    chk("rst_data",  64'(if10.mem_d),      64'd0);
    chk("rst_cnt10", 64'(if10.rx_count_0), 64'd0);
    chk("rst_cnt4",  64'(if4.rx_count_0),  64'd0);

    // One word of 2'b10 samples
    pulse(1'b1, 1'b0);
    chk("a_busy", 64'(if10.busy), 64'd1);
    exp_wr(1, 1, 10'd0, 32'hAAAAAAAA);
    send_n(16, 2'b10);
    idle(3);
    chk("a_cnt10", 64'(if10.rx_count_0), 64'd1);
    chk("a_cnt4",  64'(if4.rx_count_0),  64'd1);
    chk("a_addr10", 64'(if10.mem_a), 64'd1);

    // Async reset mid-capture, away from any clock edge
    send_n(5, 2'b01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("b_busy", 64'(if10.busy),       64'd0);
    chk("b_cnt",  64'(if10.rx_count_0), 64'd0);
    chk("b_addr", 64'(if10.mem_a),      64'd0);
    chk("b_data", 64'(if10.mem_d),      64'd0);
    chk("b_cnt4", 64'(if4.rx_count_0),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    send_n(16, 2'b11);
    idle(3);
    chk("b_post_cnt",  64'(if10.rx_count_0), 64'd0);
    chk("b_post_busy", 64'(if10.busy),       64'd0);

    // Fill the depth-4 buffer with the 0,1,2,3 pattern
    pulse(1'b1, 1'b0);
    for (int w = 0; w < 16; w++) begin
      exp_wr(1, 1, 10'(w), 32'hE4E4E4E4);
      for (int i = 0; i < 16; i++) send(2'(i % 4));
    end
    idle(3);
    chk("c_cnt4",   64'(if4.rx_count_0),  64'h10);
    chk("c_done4",  64'(if4.done),        64'd1);
    chk("c_busy4",  64'(if4.busy),        64'd0);
    chk("c_addr4",  64'(if4.mem_a),       64'd0);
    chk("c_cnt10",  64'(if10.rx_count_0), 64'd16);
    chk("c_busy10", 64'(if10.busy),       64'd1);
    exp_wr(1, 0, 10'd16, 32'h55555555);
    send_n(16, 2'b01);
    idle(3);
    chk("c_cnt4_hold", 64'(if4.rx_count_0),  64'h10);
    chk("c_cnt10_inc", 64'(if10.rx_count_0), 64'd17);

    // 40 samples then abort: two words, partial discarded
    pulse(1'b1, 1'b0);
    chk("d_done4_clr", 64'(if4.done), 64'd0);
    exp_wr(1, 1, 10'd0, 32'hFFFFFFFF);
    exp_wr(1, 1, 10'd1, 32'hFFFFFFFF);
    send_n(40, 2'b11);
    idle(2);
    pulse(1'b0, 1'b1);
    idle(1);
    chk("d_cnt10", 64'(if10.rx_count_0), 64'd2);
    chk("d_cnt4",  64'(if4.rx_count_0),  64'd2);
    chk("d_addr",  64'(if10.mem_a),      64'd2);
    chk("d_busy",  64'(if10.busy),       64'd0);
    chk("d_done",  64'(if10.done),       64'd0);
    send_n(16, 2'b00);
    idle(3);
    chk("d_cnt_hold", 64'(if10.rx_count_0), 64'd2);

    // Five words, then start+abort together
    pulse(1'b1, 1'b0);
    for (int w = 0; w < 5; w++) exp_wr(1, 1, 10'(w), 32'h55555555);
    send_n(80, 2'b01);
    idle(3);
    chk("e_cnt5",  64'(if10.rx_count_0), 64'd5);
    chk("e_cnt5b", 64'(if4.rx_count_0),  64'd5);
    pulse(1'b1, 1'b1);
    idle(1);
    chk("e_cnt0",  64'(if10.rx_count_0), 64'd0);
    chk("e_addr0", 64'(if10.mem_a),      64'd0);
    chk("e_busy",  64'(if10.busy),       64'd0);
    chk("e_done",  64'(if10.done),       64'd0);

    // Edge coinciding with the start cycle is dropped
    exp_wr(1, 1, 10'd0, 32'hAAAAAAA9);
    @(negedge clk);
    gclk  = 1'b1;
    gsign = 1'b1;
    gmag  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gclk  = 1'b0;
    @(negedge clk);
    send(2'b01);
    send_n(15, 2'b10);
    idle(3);
    chk("f_cnt", 64'(if10.rx_count_0), 64'd1);

    idle(5);
    chk("q10_empty", 64'(q10.size()), 64'd0);
    chk("q4_empty",  64'(q4.size()),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
